// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - FP32 constants, exponent bounds and state encoding shared by the softmax exponent sequencer
package softmax_pkg;

   localparam logic [31:0] FP_ONE  = 32'h3f800000;
   localparam logic [31:0] FP_INF  = 32'h7f800000;
   localparam logic [31:0] FP_QNAN = 32'h7fc00000;
   localparam logic [31:0] FP_ZERO = 32'h00000000;

   localparam logic [7:0] EXP_LO = 8'd123;
   localparam logic [7:0] EXP_HI = 8'd132;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_RUN,
      ST_GAP,
      ST_ERST,
      ST_NEXT,
      ST_SUMW,
      ST_FIN
   } state_e;

   typedef enum logic [1:0] {
      CLS_ONE,
      CLS_OVF,
      CLS_ENG
   } cls_e;

   // Small inputs round to exp(x)=1.0; large ones saturate and are flagged.
   function automatic cls_e classify(input logic [7:0] e);
      if (e <= EXP_LO) return CLS_ONE;
      if (e >= EXP_HI) return CLS_OVF;
      return CLS_ENG;
   endfunction

endpackage

// File: rtl/softmax_exp_sched_if.sv
// rtl/softmax_exp_sched_if.sv - start/done handshake and reset toward the iterative exponent engine
interface softmax_exp_sched_if;

   logic        exp_start;
   logic [31:0] exp_in;
   logic        exp_rst_n;
   logic [31:0] exp_result;
   logic        exp_done;

   modport master (
      output exp_start, exp_in, exp_rst_n,
      input  exp_result, exp_done
   );

   modport slave (
      input  exp_start, exp_in, exp_rst_n,
      output exp_result, exp_done
   );

endinterface

// File: rtl/softmax_exp_sched_add.sv
// rtl/softmax_exp_sched_add.sv - FP32 accumulator adder for non-negative operands, round to nearest even
// Only built when SOFTMAX_EXP_SUM_EN is defined; denormal operands are flushed to zero.
`ifdef SOFTMAX_EXP_SUM_EN
module softmax_exp_sched_add
   import softmax_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);

   logic [31:0] big;
   logic [31:0] small;
   logic [7:0]  eb;
   logic [7:0]  es;
   logic [7:0]  sh;
   logic [23:0] mb;
   logic [23:0] ms;
   logic [49:0] shifted;
   logic [24:0] msum;
   logic [23:0] mant;
   logic [24:0] rnd;
   logic [22:0] mant_r;
   logic [8:0]  e;
   logic        g;
   logic        s;

   always_comb begin
      big     = (a[30:0] >= b[30:0]) ? a : b;
      small   = (a[30:0] >= b[30:0]) ? b : a;
      eb      = big[30:23];
      es      = small[30:23];
      mb      = {1'b1, big[22:0]};
      ms      = (es == 8'd0) ? 24'd0 : {1'b1, small[22:0]};
      sh      = ((eb - es) > 8'd31) ? 8'd31 : (eb - es);
      shifted = {ms, 26'd0} >> sh;
      msum    = {1'b0, mb} + {1'b0, shifted[49:26]};
      if (msum[24]) begin
         mant = msum[24:1];
         g    = msum[0];
         s    = shifted[25] | (|shifted[24:0]);
         e    = {1'b0, eb} + 9'd1;
      end else begin
         mant = msum[23:0];
         g    = shifted[25];
         s    = |shifted[24:0];
         e    = {1'b0, eb};
      end
      rnd = {1'b0, mant} + {24'd0, g & (s | mant[0])};
      if (rnd[24]) e = e + 9'd1;
      mant_r = rnd[24] ? rnd[23:1] : rnd[22:0];
      if (eb == 8'hff)       y = (big[22:0] != 23'd0) ? FP_QNAN : FP_INF;
      else if (eb == 8'd0)   y = FP_ZERO;
      else if (e >= 9'd255)  y = FP_INF;
      else                   y = {big[31], e[7:0], mant_r};
   end

endmodule
`endif

// File: rtl/softmax_exp_sched.sv
// rtl/softmax_exp_sched.sv - runs N FP32 softmax scores one at a time through the shared exponent engine
// SOFTMAX_EXP_SUM_EN adds a running FP32 sum of the results on the sum port.
module softmax_exp_sched
   import softmax_pkg::*;
#(
   parameter int N   = 8,
   parameter int AW  = $clog2(N),
   parameter int TMO = 64
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          err,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_data,
`ifdef SOFTMAX_EXP_SUM_EN
   output logic [31:0]   sum,
`endif
   softmax_exp_sched_if.master eng
);

   localparam int TW = $clog2(TMO + 1);

   state_e        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic [31:0]   in_buf_q  [N];
   logic [31:0]   res_buf_q [N];
   logic          res_we;
   logic [31:0]   res_wdata;
   logic [31:0]   cur;

   assign cur = in_buf_q[idx_q];

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      res_we    = 1'b0;
      res_wdata = FP_ZERO;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FETCH;
               idx_d   = '0;
               err_d   = 1'b0;
            end
         end
         ST_FETCH: begin
            cnt_d = '0;
            case (classify(cur[30:23]))
               CLS_ONE: begin
                  res_we    = 1'b1;
                  res_wdata = FP_ONE;
                  state_d   = ST_NEXT;
               end
               CLS_OVF: begin
                  res_we    = 1'b1;
                  res_wdata = cur[31] ? FP_ZERO : FP_INF;
                  err_d     = 1'b1;
                  state_d   = ST_NEXT;
               end
               default: state_d = ST_RUN;
            endcase
         end
         ST_RUN: begin
            // Capture on the done cycle: the engine reloads its result on the following one.
            if (eng.exp_done) begin
               res_we    = 1'b1;
               res_wdata = eng.exp_result;
               cnt_d     = '0;
               state_d   = ST_GAP;
            end else if (cnt_q == TW'(TMO - 1)) begin
               res_we    = 1'b1;
               res_wdata = FP_QNAN;
               err_d     = 1'b1;
               cnt_d     = '0;
               state_d   = ST_ERST;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         ST_GAP: state_d = ST_NEXT;
         ST_ERST: begin
            if (cnt_q == TW'(1)) begin
               cnt_d   = '0;
               state_d = ST_NEXT;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         ST_NEXT: begin
            if (idx_q == AW'(N - 1)) begin
`ifdef SOFTMAX_EXP_SUM_EN
               state_d = ST_SUMW;
`else
               state_d = ST_FIN;
`endif
            end else begin
               idx_d   = idx_q + AW'(1);
               state_d = ST_FETCH;
            end
         end
         ST_SUMW: state_d = ST_FIN;
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && state_q == ST_IDLE) in_buf_q[wr_addr] <= wr_data;
      if (res_we) res_buf_q[idx_q] <= res_wdata;
   end

   assign busy          = (state_q != ST_IDLE);
   assign done          = (state_q == ST_FIN);
   assign err           = err_q;
   assign rd_data       = res_buf_q[rd_addr];
   assign eng.exp_start = (state_q == ST_RUN);
   assign eng.exp_in    = (state_q == ST_RUN) ? cur : FP_ZERO;
   assign eng.exp_rst_n = (state_q != ST_ERST);

`ifdef SOFTMAX_EXP_SUM_EN
   logic        acc_pend_q;
   logic [31:0] acc_val_q;
   logic [31:0] sum_q, sum_d;
   logic [31:0] add_y;

   softmax_exp_sched_add u_add (
      .a (sum_q),
      .b (acc_val_q),
      .y (add_y)
   );

   always_comb begin
      sum_d = sum_q;
      if (state_q == ST_IDLE && start) sum_d = FP_ZERO;
      else if (acc_pend_q)             sum_d = add_y;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_pend_q <= 1'b0;
         acc_val_q  <= FP_ZERO;
         sum_q      <= FP_ZERO;
      end else begin
         acc_pend_q <= res_we;
         acc_val_q  <= res_wdata;
         sum_q      <= sum_d;
      end
   end

   assign sum = sum_q;
`endif

endmodule

// File: tb/tb_softmax_exp_sched.sv
// tb/tb_softmax_exp_sched.sv - randomized bench for softmax_exp_sched against a behavioural engine and result model
module tb_softmax_exp_sched;

   localparam int N   = 4;
   localparam int AW  = 2;
   localparam int TMO = 64;
   localparam logic [31:0] STUCK_IN = 32'h3fc00000;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [31:0]   wr_data = '0;
   logic          start = 1'b0;
   logic          busy;
   logic          done;
   logic          err;
   logic [AW-1:0] rd_addr = '0;
   logic [31:0]   rd_data;
`ifdef SOFTMAX_EXP_SUM_EN
   logic [31:0]   sum;
`endif

   softmax_exp_sched_if eng_if ();

   softmax_exp_sched #(.N(N), .AW(AW), .TMO(TMO)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
`ifdef SOFTMAX_EXP_SUM_EN
      .sum     (sum),
`endif
      .eng     (eng_if)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Engine stand-in: result and latency are fixed functions of its operand.
   function automatic logic [31:0] eng_f(input logic [31:0] x);
      return {1'b0, x[30:0] ^ 31'h2a5c3e11};
   endfunction

   function automatic int eng_lat(input logic [31:0] x);
      return 2 + int'(x[2:0]) % 5;
   endfunction

   int eng_cnt = 0;
   always @(negedge clk) begin
      if (!eng_if.exp_rst_n || !eng_if.exp_start) begin
         eng_cnt              = 0;
         eng_if.exp_done      = 1'b0;
         eng_if.exp_result    = 32'hffffffff;
      end else begin
         eng_cnt++;
         if (eng_cnt == eng_lat(eng_if.exp_in) && eng_if.exp_in != STUCK_IN) begin
            eng_if.exp_done   = 1'b1;
            eng_if.exp_result = eng_f(eng_if.exp_in);
         end else begin
            eng_if.exp_done   = 1'b0;
            eng_if.exp_result = 32'hbad00000 | eng_cnt;
         end
      end
   end

   function automatic bit in_range(input logic [31:0] x);
      return (x[30:23] > 8'd123) && (x[30:23] < 8'd132);
   endfunction

   function automatic logic [31:0] ref_res(input logic [31:0] x);
      if (x[30:23] <= 8'd123) return 32'h3f800000;
      if (x[30:23] >= 8'd132) return x[31] ? 32'h00000000 : 32'h7f800000;
      if (x == STUCK_IN) return 32'h7fc00000;
      return eng_f(x);
   endfunction

   function automatic int ref_cycles(input logic [31:0] x);
      if (!in_range(x)) return 2;
      if (x == STUCK_IN) return 1 + TMO + 2 + 1;
      return 1 + eng_lat(x) + 1 + 1;
   endfunction

   function automatic logic [31:0] rnd_in();
      logic [31:0] x;
      if ($urandom_range(0, 9) == 0) return STUCK_IN;
      do begin
         x = {1'($urandom_range(0, 1)), 8'($urandom_range(118, 137)), 23'($urandom)};
      end while (x == STUCK_IN);
      return x;
   endfunction

   logic [31:0] vec [N];

   task automatic write_vec();
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         wr_en = 1'b1; wr_addr = AW'(i); wr_data = vec[i];
      end
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic run_vec(input string tag, input bit interfere, input bit same_wr);
      int exp_busy, exp_starts, exp_rstlo, exp_run;
      int busy_cnt, done_cnt, rstlo, starts, run_cnt, bad;
      bit exp_err, prev_s;
      exp_busy = 1; exp_starts = 0; exp_rstlo = 0; exp_run = 0; exp_err = 0;
`ifdef SOFTMAX_EXP_SUM_EN
      exp_busy = 2;
`endif
      for (int i = 0; i < N; i++) begin
         exp_busy += ref_cycles(vec[i]);
         if (in_range(vec[i])) begin
            exp_starts++;
            exp_run += (vec[i] == STUCK_IN) ? TMO : eng_lat(vec[i]);
         end
         if (vec[i] == STUCK_IN) exp_rstlo += 2;
         if (vec[i][30:23] >= 8'd132 || vec[i] == STUCK_IN) exp_err = 1'b1;
      end
      busy_cnt = 0; done_cnt = 0; rstlo = 0; starts = 0; run_cnt = 0; bad = 0; prev_s = 1'b0;
      @(negedge clk);
      start = 1'b1;
      if (same_wr) begin
         wr_en = 1'b1; wr_addr = AW'(N - 1); wr_data = vec[N - 1];
      end
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         if (!eng_if.exp_rst_n) rstlo++;
         if (eng_if.exp_start) run_cnt++;
         if (eng_if.exp_start && !prev_s) starts++;
         if (eng_if.exp_start && !eng_if.exp_rst_n) bad++;
         prev_s = eng_if.exp_start;
         start   = interfere && (c == 3);
         wr_en   = interfere && (c == 3);
         wr_addr = '0;
         wr_data = ~vec[0];
         if (done_cnt == 0) @(negedge clk);
      end
      start = 1'b0; wr_en = 1'b0;
      chk($sformatf("%s done_pulses", tag), done_cnt, 1);
      chk($sformatf("%s busy_cycles", tag), busy_cnt, exp_busy);
      chk($sformatf("%s engine_starts", tag), starts, exp_starts);
      chk($sformatf("%s run_cycles", tag), run_cnt, exp_run);
      chk($sformatf("%s eng_rst_low", tag), rstlo, exp_rstlo);
      chk($sformatf("%s start_in_rst", tag), bad, 0);
      chk($sformatf("%s err", tag), {31'd0, err}, {31'd0, exp_err});
      @(negedge clk);
      chk($sformatf("%s idle_after", tag), {30'd0, busy, done}, 32'd0);
      for (int i = 0; i < N; i++) begin
         rd_addr = AW'(i);
         #1;
         chk($sformatf("%s res[%0d]", tag, i), rd_data, ref_res(vec[i]));
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk($sformatf("%s busy", tag), {31'd0, busy}, 32'd0);
      chk($sformatf("%s done", tag), {31'd0, done}, 32'd0);
      chk($sformatf("%s err", tag), {31'd0, err}, 32'd0);
      chk($sformatf("%s exp_start", tag), {31'd0, eng_if.exp_start}, 32'd0);
      chk($sformatf("%s exp_in", tag), eng_if.exp_in, 32'd0);
      chk($sformatf("%s exp_rst_n", tag), {31'd0, eng_if.exp_rst_n}, 32'd1);
   endtask

   initial begin
      int edges;
      bit prev_s;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rstn = 1'b1;
      @(negedge clk);

      vec = '{32'h00000000, 32'h3f800000, 32'hbe800000, 32'h3e000000};
      write_vec();
      run_vec("basic", 1'b0, 1'b0);

      vec = '{32'h42200000, 32'hc2200000, STUCK_IN, 32'h3f800000};
      write_vec();
      run_vec("ovf_tmo", 1'b0, 1'b0);

      for (int i = 0; i < N; i++) vec[i] = rnd_in();
      write_vec();
      run_vec("busy_ignore", 1'b1, 1'b0);
      run_vec("rerun", 1'b0, 1'b0);

      vec[N - 1] = 32'h40000000;
      run_vec("wr_with_start", 1'b0, 1'b1);

      vec = '{32'h3f800000, 32'h3f900001, 32'h3fa00002, 32'h3fb00003};
      write_vec();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      edges = 0; prev_s = 1'b0;
      for (int c = 0; c < 500 && edges < 3; c++) begin
         if (eng_if.exp_start && !prev_s) edges++;
         prev_s = eng_if.exp_start;
         if (edges < 3) @(negedge clk);
      end
      chk("midrun reached_elem2", edges, 3);
      rstn = 1'b0;
      #1;
      chk_reset_outputs("midrun");
      @(negedge clk);
      chk("midrun no_done", {31'd0, done}, 32'd0);
      rstn = 1'b1;
      write_vec();
      run_vec("after_rst", 1'b0, 1'b0);

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < N; i++) vec[i] = rnd_in();
         write_vec();
         run_vec($sformatf("rand%0d", r), 1'b0, 1'b0);
      end

`ifdef SOFTMAX_EXP_SUM_EN
      vec = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
      write_vec();
      run_vec("sum_zeros", 1'b0, 1'b0);
      chk("sum_zeros sum", sum, 32'h40800000);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/softmax_exp_sched.md
# softmax_exp_sched

Sequencer that runs a vector of N FP32 softmax inputs through the shared iterative exponent engine, one element at a time. It sits between the input score buffer and the normaliser. It owns the engine's start/done handshake, the engine's reset, and per-element timeout. Inputs the engine cannot handle are short-circuited. Results go into a local result buffer and, optionally, into a running sum of exponentials.

## Interface
- `N`, 8: vector length (≥2).
- `AW`, $clog2(N): index width.
- `TMO`, 64: max cycles to wait for engine done per element.

- `clk` in 1: clock.
- `rstn` in 1: asynchronous active-low reset.
- `wr_en` in 1: write input buffer; ignored while `busy`.
- `wr_addr` in AW: input buffer index.
- `wr_data` in 32: FP32 input.
- `start` in 1: begin vector; ignored while `busy`.
- `busy` out 1: high from the cycle after accepted `start` until the `done` cycle, inclusive.
- `done` out 1: one-cycle pulse when the last result is written.
- `err` out 1: sticky; set by overflow/timeout; cleared by accepted `start`.
- `rd_addr` in AW: result buffer index.
- `rd_data` out 32: combinational read of the result buffer.
- `exp_start` out 1: drives engine `start_compute`.
- `exp_in` out 32: drives engine `IN_FP32`.
- `exp_rst_n` out 1: engine reset, active-low.
- `exp_result` in 32: engine `ex_temp`.
- `exp_done` in 1: engine `seq_done`.
- `sum` out 32: Σexp, valid with `done` (macro only).

## Operation
- States: IDLE, FETCH, RUN, GAP, ERST, NEXT, FIN.
- **IDLE**: `start`=1 → FETCH. On that edge: `idx`=0, `err`=0, `sum`=0.
- **FETCH**: read `in_buf[idx]` and classify on its exponent field e.
  - e≤123 (includes ±0 and denormals): write 32'h3f800000, go to NEXT.
  - e≥132 (includes Inf/NaN): if positive write 32'h7f800000, if negative write 32'h00000000; set `err`; go to NEXT.
  - Otherwise: go to RUN.
- **RUN**: `exp_start`=1 and `exp_in`=`in_buf[idx]`, both held stable. `tmo_cnt` increments each cycle.
  - `exp_done`=1 sampled: `res_buf[idx]`←`exp_result` on that edge, then GAP.
  - `tmo_cnt`==TMO−1 without done: write 32'h7fc00000, set `err`, go to ERST.
- **GAP**: one cycle with `exp_start`=0 so the engine returns to its idle state. Then NEXT.
- **ERST**: `exp_rst_n`=0 for exactly 2 cycles, then NEXT.
- **NEXT**: if `idx`==N−1 → FIN, otherwise `idx`+1 → FETCH.
- **FIN**: `done`=1 for one cycle, then IDLE.
- `exp_start` deasserts on the edge after `exp_done`. The engine reloads `ex_temp` during that overlapping cycle, so the capture must use the `exp_done`-cycle value.
- `wr_en` and `start` together in IDLE: the write lands; the run reads the new value.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `exp_start`=0, `exp_in`=0, `exp_rst_n`=1, `sum`=0, state IDLE, `idx`=0. Buffer contents are undefined.
- Bypassed element: 2 cycles (FETCH, NEXT).
- Engine element: 1 (FETCH) + k (RUN, k = cycles to `exp_done` inclusive, k≥2 because the engine's first cycle loads its operand) + 1 (GAP) + 1 (NEXT).
- Timeout element: 1 + TMO + 2 + 1 cycles.
- `rstn` low mid-run: immediate return to IDLE with all outputs at reset values. No `done` is issued.

## Configuration
- `SOFTMAX_EXP_SUM_EN` defined:
  - Each written result is added into `sum` on the cycle after the write, using one FP32 adder.
  - FIN is delayed one cycle so the last add completes; `sum` is stable from `done` until the next accepted `start`.
  - An Inf result makes `sum` Inf; a qNaN result makes `sum` qNaN.
- Undefined: `sum` port absent, no adder, FIN immediately after the last NEXT.

## Structure
- Shared package `softmax_pkg`:
  - FP32 constants FP_ONE=32'h3f800000, FP_INF=32'h7f800000, FP_QNAN=32'h7fc00000, FP_ZERO.
  - Exponent bounds EXP_LO=123, EXP_HI=132.
  - State enum.
- One sub-module under the macro: the existing FP32 `add_sub` instance as the accumulator adder.
- The engine is instantiated outside this block by the softmax top.

## Test plan
- N=4, inputs {32'h00000000, 32'h3f800000, 32'hbe800000, 32'h3e000000}, engine behavioural model: results {3f800000, ≈402df854, ≈3f475f7d, ≈3f910b02}; `err`=0; `done` once; `exp_start` high only during RUN.
- Input 32'h42200000 (40.0) → 7f800000 with `err`=1, engine never started. Input 32'hc2200000 → 00000000.
- Stub engine never asserts `exp_done` → after 64 RUN cycles `exp_rst_n` is low for 2 cycles, result is 7fc00000, `err`=1, and the remaining elements still process.
- `start` pulsed while `busy`, and `wr_en` while `busy` → no effect on results or buffer.
- `rstn` low during RUN of element 2 → outputs at reset values; a new `start` then completes normally.
- With `SOFTMAX_EXP_SUM_EN`: four inputs of 0.0 → `sum`=32'h40800000 at `done`.
